// File: rtl/conv_tile_wr_addr.sv
// Halo write-address generator: routes bottom-row pixels of a tile to top RAM
// and right-column pixels to side RAM. WR_ADDR_BOUND_CHK_EN adds oob_o.
module conv_tile_wr_addr #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 13,
  parameter int TILE_H    = 8,
  parameter int TOP_DEPTH = 8192
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [2:0]        layer_i,
  input  logic [ADDR_W-1:0] top_offset_i,
  input  logic [ADDR_W-1:0] side_offset_i,
  input  logic              pix_valid_i,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic              pix_ready_o,
  output logic              top_we_o,
  output logic [ADDR_W-1:0] top_addr_o,
  output logic [DATA_W-1:0] top_data_o,
  output logic              side_we_o,
  output logic [ADDR_W-1:0] side_addr_o,
  output logic [DATA_W-1:0] side_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef WR_ADDR_BOUND_CHK_EN
  ,output logic             oob_o
`endif
);

  localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] top_off_q, side_off_q;
  logic [3:0]        wm1_q, wm1_d;
  logic [3:0]        col;
  logic [RW-1:0]     row;
  logic              acc, last_col, last_row;
  logic              start_ok, start_bad;
  logic              top_hit;

  assign start_ok  = (state == IDLE) && start_i && (layer_i <= 3'd5);
  assign start_bad = (state == IDLE) && start_i && (layer_i > 3'd5);
  assign acc       = (state == RUN) && pix_valid_i;
  assign last_col  = (col == wm1_q);
  assign last_row  = (row == RW'(TILE_H-1));

  assign pix_ready_o = (state == RUN);
  assign busy_o      = (state == LOAD) || (state == RUN);
  assign done_o      = (state == DONE);

  // Tile width minus one, so the last-column test is a plain compare
  always_comb begin
    wm1_d = 4'd0;
    unique case (1'b1)
      (layer_i <= 3'd1): wm1_d = 4'd15;
      (layer_i == 3'd2): wm1_d = 4'd7;
      (layer_i == 3'd3): wm1_d = 4'd3;
      (layer_i == 3'd4): wm1_d = 4'd1;
      default:           wm1_d = 4'd0;
    endcase
  end

`ifdef WR_ADDR_BOUND_CHK_EN
  logic [ADDR_W:0] top_sum;
  logic            top_oob;
  assign top_sum = {1'b0, top_off_q} + (ADDR_W+1)'(col);
  assign top_oob = top_sum >= (ADDR_W+1)'(TOP_DEPTH);
  assign top_hit = acc && last_row && !top_oob;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      oob_o <= 1'b0;
    else if (start_ok)
      oob_o <= 1'b0;
    else if (acc && last_row && top_oob)
      oob_o <= 1'b1;
  end
`else
  assign top_hit = acc && last_row;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start_ok) nxt = LOAD;
      LOAD:    nxt = RUN;
      RUN:     if (acc && last_col && last_row) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      top_off_q   <= '0;
      side_off_q  <= '0;
      wm1_q       <= '0;
      col         <= '0;
      row         <= '0;
      top_we_o    <= 1'b0;
      top_addr_o  <= '0;
      top_data_o  <= '0;
      side_we_o   <= 1'b0;
      side_addr_o <= '0;
      side_data_o <= '0;
      err_o       <= 1'b0;
    end else begin
      state     <= nxt;
      err_o     <= start_bad;
      top_we_o  <= top_hit;
      side_we_o <= acc && last_col;
      if (start_ok) begin
        top_off_q  <= top_offset_i;
        side_off_q <= side_offset_i;
        wm1_q      <= wm1_d;
      end
      if (state == LOAD) begin
        col <= '0;
        row <= '0;
      end
      if (acc) begin
        top_addr_o  <= top_off_q + ADDR_W'(col);
        top_data_o  <= pix_data_i;
        side_addr_o <= side_off_q + ADDR_W'(row);
        side_data_o <= pix_data_i;
        if (last_col) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_wr_addr.sv
// Randomized bench for conv_tile_wr_addr against a pixel-index model
// (row = k / W, col = k % W) of the halo write pattern.
module tb_conv_tile_wr_addr;

`ifdef WR_ADDR_BOUND_CHK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  layer = '0;
  logic [12:0] top_off = '0, side_off = '0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        ready, top_we, side_we, busy, done, err;
  logic [12:0] top_addr, side_addr;
  logic [15:0] top_data, side_data;
  logic        oob;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  conv_tile_wr_addr dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .layer_i(layer),
    .top_offset_i(top_off), .side_offset_i(side_off),
    .pix_valid_i(valid), .pix_data_i(data), .pix_ready_o(ready),
    .top_we_o(top_we), .top_addr_o(top_addr), .top_data_o(top_data),
    .side_we_o(side_we), .side_addr_o(side_addr), .side_data_o(side_data),
    .busy_o(busy), .done_o(done), .err_o(err)
`ifdef WR_ADDR_BOUND_CHK_EN
    , .oob_o(oob)
`endif
  );

`ifndef WR_ADDR_BOUND_CHK_EN
  assign oob = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_twe"}, top_we, 0);
    chk({tag, "_taddr"}, top_addr, 0);
    chk({tag, "_tdata"}, top_data, 0);
    chk({tag, "_swe"}, side_we, 0);
    chk({tag, "_saddr"}, side_addr, 0);
    chk({tag, "_sdata"}, side_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic run_tile(input int lay, input int top, input int side,
                          input bit gaps, input int abort_at,
                          input bit mid_start);
    int w, n, k, pend, r, c, cyc;
    logic [15:0] pd;
    bit exp_oob, over;
    w = (lay <= 1) ? 16 : (16 >> (lay - 1));
    n = w * 8;
    k = 0;
    pend = -1;
    pd = '0;
    exp_oob = 1'b0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1; layer = 3'(lay);
    top_off = 13'(top); side_off = 13'(side);
    valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ready", ready, 0);
    forever begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (pend < 0) begin
        chk("gap_twe", top_we, 0);
        chk("gap_swe", side_we, 0);
      end else begin
        r = pend / w;
        c = pend % w;
        over = BC && (top + c >= 8192);
        if (r == 7 && over) exp_oob = 1'b1;
        chk("twe", top_we, (r == 7 && !over) ? 1 : 0);
        if (r == 7 && !over) begin
          chk("taddr", top_addr, (top + c) % 8192);
          chk("tdata", top_data, pd);
        end
        chk("swe", side_we, (c == w - 1) ? 1 : 0);
        if (c == w - 1) begin
          chk("saddr", side_addr, (side + r) % 8192);
          chk("sdata", side_data, pd);
        end
      end
      if (BC) chk("oob", oob, exp_oob);
      if (k == n) break;
      if (cyc > 2000) begin
        chk("timeout", 1, 0);
        valid = 1'b0;
        return;
      end
      chk("run_ready", ready, 1);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      if (k == abort_at) begin
        rst_n = 1'b0;
        valid = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        rst_n = 1'b1;
        valid = 1'b0;
        return;
      end
      if (mid_start && k == 3) begin
        start = 1'b1;
        layer = 3'd5;
        top_off = 13'(top + 1000);
        side_off = 13'(side + 77);
      end
      valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data = 16'($urandom);
      pd = data;
      pend = valid ? k : -1;
      if (valid) k++;
    end
    valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_ready", ready, 0);
    chk("done_busy", busy, 0);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_twe", top_we, 0);
    chk("idle_swe", side_we, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    valid = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    if (BC) chk("reset_oob", oob, 0);
    start = 1'b0;
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_tile(0, 16, 8, 1'b0, -1, 1'b0);
    run_tile(5, 5, 0, 1'b0, -1, 1'b0);
    run_tile(3, 100, 200, 1'b1, -1, 1'b0);
    run_tile(1, 300, 40, 1'b0, -1, 1'b1);
    run_tile(0, 50, 60, 1'b0, 40, 1'b0);
    run_tile(0, 70, 90, 1'b0, -1, 1'b0);

    @(negedge clk);
    start = 1'b1; layer = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_clear", err, 0);
    chk("err_busy2", busy, 0);
    start = 1'b1; layer = 3'd6;
    @(negedge clk);
    start = 1'b0;
    chk("err6_pulse", err, 1);

    run_tile(0, 8190, 8188, 1'b0, -1, 1'b0);
    run_tile(4, 8191, 8191, 1'b1, -1, 1'b0);

    for (int i = 0; i < 6; i++)
      run_tile(int'($urandom_range(0, 5)), int'($urandom_range(0, 8191)),
               int'($urandom_range(0, 8191)), 1'b1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
